// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer:
// load/store size codes and FSM state encoding.
package mem_access_ctrl_pkg;

    // load_option / store size codes
    localparam logic [2:0] SZ_LB  = 3'd0;
    localparam logic [2:0] SZ_LBU = 3'd1;
    localparam logic [2:0] SZ_LH  = 3'd2;
    localparam logic [2:0] SZ_LHU = 3'd3;
    localparam logic [2:0] SZ_LW  = 3'd4;
    localparam logic [2:0] SZ_SB  = 3'd0;
    localparam logic [2:0] SZ_SH  = 3'd2;
    localparam logic [2:0] SZ_SW  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte-sized access (signed or unsigned load, or sb)
    function automatic logic is_byte_size(input logic [2:0] size);
        return (size == SZ_LB) || (size == SZ_LBU);
    endfunction

    // Halfword-sized access (signed or unsigned load, or sh)
    function automatic logic is_half_size(input logic [2:0] size);
        return (size == SZ_LH) || (size == SZ_LHU);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side op bus, data-memory handshake and load-extender outputs
// of the MEM-stage sequencer, bundled as one interface.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    // EX/MEM op
    logic              op_valid;
    logic              op_store;
    logic [2:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              flush;
    // data memory
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ready;
    logic [31:0]       dm_rdata;
    // pipeline control and load extender
    logic              stall;
    logic              ld_done;
    logic [31:0]       ld_dout;
    logic [1:0]        ld_addr;
    logic [2:0]        ld_option;
    logic              addr_err;
    logic              bus_err;

    // Sequencer view
    modport slave (
        input  op_valid, op_store, op_size, op_addr, op_wdata, flush,
        input  dm_ready, dm_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output stall, ld_done, ld_dout, ld_addr, ld_option, addr_err, bus_err
    );

    // Pipeline + memory view (drives ops and memory responses)
    modport master (
        output op_valid, op_store, op_size, op_addr, op_wdata, flush,
        output dm_ready, dm_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  stall, ld_done, ld_dout, ld_addr, ld_option, addr_err, bus_err
    );
endinterface

// File: rtl/mem_access_ctrl_store_lane_gen.sv
// Combinational lane generator: byte enables, lane-replicated store
// data and alignment check for one memory op.
module store_lane_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);
    logic size_byte;
    logic size_half;
    logic size_word;

    assign size_byte = is_byte_size(size_i);
    assign size_half = is_half_size(size_i);
    assign size_word = (size_i == SZ_LW);

    // Alignment check and byte enables; loads always fetch the whole word
    always_comb begin
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        if (size_half) begin
            misaligned_o = addr_lo_i[0];
        end else if (size_word) begin
            misaligned_o = |addr_lo_i;
        end else if (!size_byte) begin
            misaligned_o = 1'b1;
        end
        if (store_i) begin
            if (size_byte) begin
                be_o = 4'b0001 << addr_lo_i;
            end else if (size_half) begin
                be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // Replicate the right-aligned store data into every lane it may land in
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_o[8*gi +: 8] = size_byte ? wdata_i[7:0] :
                                        size_half ? wdata_i[8*(gi%2) +: 8] :
                                                    wdata_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: accepts one op in IDLE, holds a
// req/ready handshake in WAIT (with timeout), reports in RESP.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              req_q,       req_d;
    logic              we_q,        we_d;
    logic [3:0]        be_q,        be_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [1:0]        ld_addr_q,   ld_addr_d;
    logic [2:0]        ld_option_q, ld_option_d;
    logic [31:0]       ld_dout_q,   ld_dout_d;
    logic              addr_err_q,  addr_err_d;
    logic              bus_err_q,   bus_err_d;
    logic              kill_q,      kill_d;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              lane_mis;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    store_lane_gen u_lane (
        .store_i      (bus.op_store),
        .size_i       (bus.op_size),
        .addr_lo_i    (bus.op_addr[1:0]),
        .wdata_i      (bus.op_wdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (lane_mis)
    );

    assign accept  = (state_q == ST_IDLE) && bus.op_valid && !bus.flush && !lane_mis;
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state logic: request launch, handshake completion and timeout
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ld_addr_d   = ld_addr_q;
        ld_option_d = ld_option_q;
        ld_dout_d   = ld_dout_q;
        kill_d      = kill_q;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                kill_d = 1'b0;
                if (bus.op_valid && !bus.flush && lane_mis) begin
                    addr_err_d = 1'b1;
                end
                if (accept) begin
                    req_d       = 1'b1;
                    we_d        = bus.op_store;
                    be_d        = lane_be;
                    addr_d      = {bus.op_addr[ADDR_W-1:2], 2'b00};
                    wdata_d     = lane_wdata;
                    ld_addr_d   = bus.op_addr[1:0];
                    ld_option_d = bus.op_size;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A flush cannot abort the bus transaction; remember it instead
                if (bus.flush) begin
                    kill_d = 1'b1;
                end
                if (bus.dm_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        ld_dout_d = bus.dm_rdata;
                    end
                end else if (cnt_inc == CNT_LAST) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ld_addr_q   <= '0;
            ld_option_q <= '0;
            ld_dout_q   <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ld_addr_q   <= ld_addr_d;
            ld_option_q <= ld_option_d;
            ld_dout_q   <= ld_dout_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
            kill_q      <= kill_d;
        end
    end

    assign bus.dm_req    = req_q;
    assign bus.dm_we     = we_q;
    assign bus.dm_be     = be_q;
    assign bus.dm_addr   = addr_q;
    assign bus.dm_wdata  = wdata_q;
    assign bus.ld_dout   = ld_dout_q;
    assign bus.ld_addr   = ld_addr_q;
    assign bus.ld_option = ld_option_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.bus_err   = bus_err_q;
    // Stall releases in RESP so the pipeline advances with ld_done
    assign bus.stall     = accept || (state_q == ST_WAIT);
    assign bus.ld_done   = (state_q == ST_RESP) && !we_q && !kill_q && !bus.flush;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed ops, a per-cycle
// request monitor driven by an arithmetic model, and literal pins.
module tb_mem_access_ctrl;
    localparam int TIMEOUT    = 16;
    localparam int NO_READY   = -1;
    localparam int NO_FLUSH   = -1;
    localparam int RESP_FLUSH = 99;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(32)) bus_if ();

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // current op as seen by the model
    logic        m_store   = 1'b0;
    logic [2:0]  m_size    = 3'd0;
    logic [31:0] m_addr    = 32'd0;
    logic [31:0] m_wdata   = 32'd0;
    logic        m_done_ok = 1'b0;

    // first-WAIT-cycle observations, pinned against literals
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd1: return 1;
            3'd2, 3'd3: return 2;
            3'd4:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] s, input logic [31:0] a);
        int n;
        n = nbytes(s);
        return (n == 0) || ((a % n) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] s, input logic [31:0] a);
        int n;
        n = nbytes(s);
        if (!st) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] w);
        case (nbytes(s))
            1:       return w[7:0] * 32'h0101_0101;
            2:       return w[15:0] * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    // Every cycle a request is on the bus it must match the model op
    always @(negedge clk) begin
        if (bus_if.dm_req) begin
            check("mon_dm_addr", bus_if.dm_addr, m_addr & ~32'd3);
            check("mon_dm_be", {28'd0, bus_if.dm_be}, {28'd0, model_be(m_store, m_size, m_addr)});
            check("mon_dm_we", {31'd0, bus_if.dm_we}, {31'd0, m_store});
            if (m_store) check("mon_dm_wdata", bus_if.dm_wdata, model_wd(m_size, m_wdata));
            check("mon_stall_in_req", {31'd0, bus_if.stall}, 32'd1);
        end
        if (bus_if.ld_done) check("mon_ld_done_allowed", 32'd1, {31'd0, m_done_ok});
    end

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, {17'd0, bus_if.dm_req, bus_if.dm_we, bus_if.dm_be, bus_if.stall,
                              bus_if.ld_done, bus_if.ld_addr, bus_if.ld_option,
                              bus_if.addr_err, bus_if.bus_err}, 32'd0);
        check({nm, "_dm_addr"}, bus_if.dm_addr, 32'd0);
        check({nm, "_dm_wdata"}, bus_if.dm_wdata, 32'd0);
        check({nm, "_ld_dout"}, bus_if.ld_dout, 32'd0);
    endtask

    // One op: rdy_at = WAIT cycle (1-based) with dm_ready, flush_at = WAIT
    // cycle with flush (or RESP_FLUSH), exp_stall = hand-counted stall cycles
    task automatic run_op(input string nm, input logic st, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] w, input int rdy_at,
                          input logic [31:0] rd, input int flush_at, input int exp_stall);
        int  stall_n = 0;
        bit  done    = 0;
        bit  killed;
        bit  mis_op;
        mis_op    = model_mis(sz, a);
        killed    = (flush_at > 0);
        m_store   = st;
        m_size    = sz;
        m_addr    = a;
        m_wdata   = w;
        m_done_ok = !st && !killed && !mis_op && (rdy_at > 0);
        @(posedge clk); #1;
        bus_if.op_valid = 1'b1;
        bus_if.op_store = st;
        bus_if.op_size  = sz;
        bus_if.op_addr  = a;
        bus_if.op_wdata = w;
        @(negedge clk);
        if (bus_if.stall) stall_n++;
        @(posedge clk); #1;
        bus_if.op_valid = 1'b0;
        if (mis_op) begin
            @(negedge clk);
            check({nm, "_addr_err"}, {31'd0, bus_if.addr_err}, 32'd1);
            check({nm, "_no_req"}, {31'd0, bus_if.dm_req}, 32'd0);
            check({nm, "_stall"}, stall_n, exp_stall);
            @(negedge clk);
            check({nm, "_addr_err_pulse"}, {31'd0, bus_if.addr_err}, 32'd0);
        end else begin
            for (int c = 1; c <= TIMEOUT; c++) begin
                bus_if.dm_ready = (c == rdy_at);
                bus_if.dm_rdata = rd;
                bus_if.flush    = (c == flush_at);
                @(negedge clk);
                if (bus_if.stall) stall_n++;
                if (c == 1) begin
                    obs_addr  = bus_if.dm_addr;
                    obs_be    = bus_if.dm_be;
                    obs_wdata = bus_if.dm_wdata;
                    obs_we    = bus_if.dm_we;
                end
                if (c == rdy_at) begin
                    done = 1;
                    break;
                end
                if (c == TIMEOUT) break;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            bus_if.dm_ready = 1'b0;
            bus_if.flush    = (flush_at == RESP_FLUSH);
            @(negedge clk);
            check({nm, "_req_dropped"}, {31'd0, bus_if.dm_req}, 32'd0);
            check({nm, "_stall_after"}, {31'd0, bus_if.stall}, 32'd0);
            if (done) begin
                check({nm, "_ld_done"}, {31'd0, bus_if.ld_done}, {31'd0, m_done_ok});
                check({nm, "_no_bus_err"}, {31'd0, bus_if.bus_err}, 32'd0);
                if (!st) begin
                    check({nm, "_ld_dout"}, bus_if.ld_dout, rd);
                    check({nm, "_ld_addr"}, {30'd0, bus_if.ld_addr}, {30'd0, a[1:0]});
                    check({nm, "_ld_option"}, {29'd0, bus_if.ld_option}, {29'd0, sz});
                end
            end else begin
                check({nm, "_bus_err"}, {31'd0, bus_if.bus_err}, 32'd1);
                check({nm, "_ld_done"}, {31'd0, bus_if.ld_done}, 32'd0);
            end
            check({nm, "_stall_cycles"}, stall_n, exp_stall);
            @(posedge clk); #1;
            bus_if.flush = 1'b0;
            @(negedge clk);
            check({nm, "_idle_pulses"}, {30'd0, bus_if.ld_done, bus_if.bus_err}, 32'd0);
        end
        $display("op %s store=%0d size=%0d addr=%h stall_cycles=%0d", nm, st, sz, a, stall_n);
    endtask

    initial begin
        bus_if.op_valid = 1'b0;
        bus_if.op_store = 1'b0;
        bus_if.op_size  = 3'd0;
        bus_if.op_addr  = 32'd0;
        bus_if.op_wdata = 32'd0;
        bus_if.flush    = 1'b0;
        bus_if.dm_ready = 1'b0;
        bus_if.dm_rdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // lw, 3-cycle memory
        run_op("lw_1000", 1'b0, 3'd4, 32'h0000_1000, 32'd0, 3, 32'hDEAD_BEEF, NO_FLUSH, 4);
        check("lw_1000_pin_addr", obs_addr, 32'h0000_1000);
        check("lw_1000_pin_be", {28'd0, obs_be}, 32'hF);
        // sb to top lane
        run_op("sb_2003", 1'b1, 3'd0, 32'h0000_2003, 32'h0000_00A5, 1, 32'd0, NO_FLUSH, 2);
        check("sb_2003_pin_be", {28'd0, obs_be}, 32'h8);
        check("sb_2003_pin_wdata", obs_wdata, 32'hA5A5_A5A5);
        check("sb_2003_pin_we", {31'd0, obs_we}, 32'd1);
        // misaligned halfword load
        run_op("lh_2001", 1'b0, 3'd2, 32'h0000_2001, 32'd0, 1, 32'd0, NO_FLUSH, 0);
        // sh to upper half
        run_op("sh_3002", 1'b1, 3'd2, 32'h0000_3002, 32'h0000_1234, 2, 32'd0, NO_FLUSH, 3);
        check("sh_3002_pin_be", {28'd0, obs_be}, 32'hC);
        check("sh_3002_pin_wdata", obs_wdata, 32'h1234_1234);
        // lbu, memory never answers
        run_op("lbu_tmo", 1'b0, 3'd1, 32'h0000_5001, 32'd0, NO_READY, 32'd0, NO_FLUSH, 17);
        // ready on the last allowed cycle: completion wins
        run_op("lw_last", 1'b0, 3'd4, 32'h0000_6000, 32'd0, 16, 32'h0BAD_F00D, NO_FLUSH, 17);
        // flush in WAIT: handshake completes, no ld_done
        run_op("lw_flush", 1'b0, 3'd4, 32'h0000_7000, 32'd0, 4, 32'h1122_3344, 2, 5);
        // flush in RESP suppresses ld_done
        run_op("lb_rflush", 1'b0, 3'd0, 32'h0000_8002, 32'd0, 1, 32'hCAFE_BABE, RESP_FLUSH, 2);
        // lh upper half, zero-wait memory
        run_op("lh_9002", 1'b0, 3'd2, 32'h0000_9002, 32'd0, 1, 32'h5566_7788, NO_FLUSH, 2);
        check("lh_9002_pin_ld_addr", {30'd0, bus_if.ld_addr}, 32'd2);
        // misaligned word store and reserved size
        run_op("sw_a001", 1'b1, 3'd4, 32'h0000_A001, 32'h1111_1111, 1, 32'd0, NO_FLUSH, 0);
        run_op("ld_sz5", 1'b0, 3'd5, 32'h0000_B000, 32'd0, 1, 32'd0, NO_FLUSH, 0);
        // sw aligned
        run_op("sw_c000", 1'b1, 3'd4, 32'h0000_C000, 32'h89AB_CDEF, 2, 32'd0, NO_FLUSH, 3);
        check("sw_c000_pin_wdata", obs_wdata, 32'h89AB_CDEF);

        // reset while in WAIT
        m_store = 1'b0; m_size = 3'd4; m_addr = 32'h0000_4004; m_wdata = 32'd0; m_done_ok = 1'b0;
        @(posedge clk); #1;
        bus_if.op_valid = 1'b1; bus_if.op_store = 1'b0; bus_if.op_size = 3'd4;
        bus_if.op_addr = 32'h0000_4004;
        @(posedge clk); #1;
        bus_if.op_valid = 1'b0;
        @(negedge clk);
        check("rst_wait_req", {31'd0, bus_if.dm_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("rst_wait");
        $display("op rst_in_wait addr=%h", m_addr);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
